// File: rtl/ss_div_pkg.sv
// Shared types and helpers for the signed/unsigned divider front end.
// The optional watchdog is enabled by defining SS_DIV_TIMEOUT_EN.
package ss_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } ss_div_state_e;

    typedef struct packed {
        logic div_by_zero;
        logic overflow;
        logic timeout;
    } ss_div_flags_t;

    // Most negative two's-complement value for a given width (widths up to 64).
    function automatic logic [63:0] ss_div_min(input int unsigned width);
        ss_div_min = 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/ss_div_sign_fix.sv
// Conditional two's-complement negate: used both to form operand magnitudes
// and to restore the sign of the divider's quotient and remainder.
module ss_div_sign_fix #(
    parameter int SIZE_DATA = 32
) (
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic                 i_neg,
    output logic [SIZE_DATA-1:0] o_data
);

    // Negate when requested, pass through otherwise.
    always_comb begin
        o_data = i_neg ? ((~i_data) + SIZE_DATA'(1)) : i_data;
    end

endmodule

// File: rtl/ss_div_sign_ctrl.sv
// Request/response front end for the unsigned sequential divider.
// Handles sign conversion, divide-by-zero and signed MIN/-1 locally.
// Define SS_DIV_TIMEOUT_EN to add a watchdog on the divider's response.
module ss_div_sign_ctrl
    import ss_div_pkg::*;
#(
    parameter int SIZE_DATA      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_signed,
    input  logic [SIZE_DATA-1:0] i_dividend,
    input  logic [SIZE_DATA-1:0] i_divisor,
    output logic                 o_div_en,
    output logic [SIZE_DATA-1:0] o_div_dividend,
    output logic [SIZE_DATA-1:0] o_div_divisor,
    input  logic [SIZE_DATA-1:0] i_div_quotient,
    input  logic [SIZE_DATA-1:0] i_div_remainder,
    input  logic                 i_div_valid,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [SIZE_DATA-1:0] o_quotient,
    output logic [SIZE_DATA-1:0] o_remainder,
    output logic                 o_div_by_zero,
    output logic                 o_overflow,
    output logic                 o_timeout
);

    localparam logic [SIZE_DATA-1:0] MIN_VAL = SIZE_DATA'(ss_div_min(SIZE_DATA));
    localparam int MSB = SIZE_DATA - 1;

    ss_div_state_e        state_q, state_d;
    logic                 signed_q, signed_d;
    logic                 sign_quot_q, sign_quot_d;
    logic                 sign_rem_q, sign_rem_d;
    logic                 div_en_q, div_en_d;
    logic [SIZE_DATA-1:0] div_dividend_q, div_dividend_d;
    logic [SIZE_DATA-1:0] div_divisor_q, div_divisor_d;
    logic [SIZE_DATA-1:0] quotient_q, quotient_d;
    logic [SIZE_DATA-1:0] remainder_q, remainder_d;
    ss_div_flags_t        flags_q, flags_d;

    logic [SIZE_DATA-1:0] mag_dividend, mag_divisor;
    logic [SIZE_DATA-1:0] fixed_quot, fixed_rem;
    logic                 accept, divisor_zero, overflow_case, timeout_hit;

`ifdef SS_DIV_TIMEOUT_EN
    localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_W   = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

    // Operand magnitudes: only signed requests with a negative operand are negated.
    ss_div_sign_fix #(.SIZE_DATA(SIZE_DATA)) u_fix_dividend (
        .i_data (i_dividend),
        .i_neg  (i_signed & i_dividend[MSB]),
        .o_data (mag_dividend)
    );
    ss_div_sign_fix #(.SIZE_DATA(SIZE_DATA)) u_fix_divisor (
        .i_data (i_divisor),
        .i_neg  (i_signed & i_divisor[MSB]),
        .o_data (mag_divisor)
    );

    // Result correction: quotient follows the operand sign XOR, remainder the dividend sign.
    ss_div_sign_fix #(.SIZE_DATA(SIZE_DATA)) u_fix_quot (
        .i_data (i_div_quotient),
        .i_neg  (signed_q & sign_quot_q),
        .o_data (fixed_quot)
    );
    ss_div_sign_fix #(.SIZE_DATA(SIZE_DATA)) u_fix_rem (
        .i_data (i_div_remainder),
        .i_neg  (signed_q & sign_rem_q),
        .o_data (fixed_rem)
    );

    assign accept        = i_req_valid && (state_q == ST_IDLE);
    assign divisor_zero  = (i_divisor == '0);
    assign overflow_case = i_signed && (i_dividend == MIN_VAL) && (i_divisor == '1);

    // Next-state and datapath logic for the IDLE/ISSUE/WAIT/RESP sequence.
    always_comb begin
        state_d        = state_q;
        signed_d       = signed_q;
        sign_quot_d    = sign_quot_q;
        sign_rem_d     = sign_rem_q;
        div_en_d       = 1'b0;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        flags_d        = flags_q;
`ifdef SS_DIV_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    signed_d    = i_signed;
                    sign_quot_d = i_dividend[MSB] ^ i_divisor[MSB];
                    sign_rem_d  = i_dividend[MSB];
                    if (divisor_zero) begin
                        quotient_d  = '1;
                        remainder_d = i_dividend;
                        flags_d     = '{div_by_zero: 1'b1, overflow: 1'b0, timeout: 1'b0};
                        state_d     = ST_RESP;
                    end else if (overflow_case) begin
                        quotient_d  = MIN_VAL;
                        remainder_d = '0;
                        flags_d     = '{div_by_zero: 1'b0, overflow: 1'b1, timeout: 1'b0};
                        state_d     = ST_RESP;
                    end else begin
                        div_dividend_d = mag_dividend;
                        div_divisor_d  = mag_divisor;
                        div_en_d       = 1'b1;
                        state_d        = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
`ifdef SS_DIV_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
`ifdef SS_DIV_TIMEOUT_EN
                cnt_d = cnt_q + CNT_W'(1);
`endif
                if (i_div_valid) begin
                    quotient_d  = fixed_quot;
                    remainder_d = fixed_rem;
                    flags_d     = '0;
                    state_d     = ST_RESP;
                end else if (timeout_hit) begin
                    quotient_d  = '1;
                    remainder_d = '0;
                    flags_d     = '{div_by_zero: 1'b0, overflow: 1'b0, timeout: 1'b1};
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    flags_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any request in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_IDLE;
            signed_q       <= 1'b0;
            sign_quot_q    <= 1'b0;
            sign_rem_q     <= 1'b0;
            div_en_q       <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            flags_q        <= '0;
`ifdef SS_DIV_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            signed_q       <= signed_d;
            sign_quot_q    <= sign_quot_d;
            sign_rem_q     <= sign_rem_d;
            div_en_q       <= div_en_d;
            div_dividend_q <= div_dividend_d;
            div_divisor_q  <= div_divisor_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            flags_q        <= flags_d;
`ifdef SS_DIV_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

    assign o_req_ready    = (state_q == ST_IDLE);
    assign o_rsp_valid    = (state_q == ST_RESP);
    assign o_div_en       = div_en_q;
    assign o_div_dividend = div_dividend_q;
    assign o_div_divisor  = div_divisor_q;
    assign o_quotient     = quotient_q;
    assign o_remainder    = remainder_q;
    assign o_div_by_zero  = flags_q.div_by_zero;
    assign o_overflow     = flags_q.overflow;
    assign o_timeout      = flags_q.timeout;

endmodule

// File: tb/tb_ss_div_sign_ctrl.sv
// Directed, table-driven bench for ss_div_sign_ctrl with a 5-cycle divider model.
module tb_ss_div_sign_ctrl;

    localparam int W = 32;
    localparam int TO = 255;

    logic         i_clk = 1'b0;
    logic         i_rst_n = 1'b0;
    logic         i_req_valid = 1'b0;
    logic         o_req_ready;
    logic         i_signed = 1'b0;
    logic [W-1:0] i_dividend = '0;
    logic [W-1:0] i_divisor = '0;
    logic         o_div_en;
    logic [W-1:0] o_div_dividend, o_div_divisor;
    logic [W-1:0] i_div_quotient = '0;
    logic [W-1:0] i_div_remainder = '0;
    logic         i_div_valid = 1'b0;
    logic         o_rsp_valid;
    logic         i_rsp_ready = 1'b0;
    logic [W-1:0] o_quotient, o_remainder;
    logic         o_div_by_zero, o_overflow, o_timeout;

    ss_div_sign_ctrl #(.SIZE_DATA(W), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_signed(i_signed), .i_dividend(i_dividend), .i_divisor(i_divisor),
        .o_div_en(o_div_en), .o_div_dividend(o_div_dividend), .o_div_divisor(o_div_divisor),
        .i_div_quotient(i_div_quotient), .i_div_remainder(i_div_remainder),
        .i_div_valid(i_div_valid),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_quotient(o_quotient), .o_remainder(o_remainder),
        .o_div_by_zero(o_div_by_zero), .o_overflow(o_overflow), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Behavioural divider: samples operands on o_div_en, answers 5 cycles later.
    int           en_count = 0;
    int           mcnt = 0;
    bit           model_silent = 1'b0;
    bit           stray_req = 1'b0;
    logic [W-1:0] ma = '0, mb = '0;

    always @(negedge i_clk) begin
        i_div_valid = 1'b0;
        if (stray_req) begin
            i_div_valid     = 1'b1;
            i_div_quotient  = 32'h1234_5678;
            i_div_remainder = 32'h9abc_def0;
            stray_req       = 1'b0;
        end
        if (!i_rst_n) begin
            mcnt = 0;
        end else if (o_div_en === 1'b1) begin
            en_count++;
            ma = o_div_dividend;
            mb = o_div_divisor;
            if (!model_silent) mcnt = 5;
        end else if (mcnt > 0) begin
            mcnt--;
            if (mcnt == 0) begin
                i_div_valid     = 1'b1;
                i_div_quotient  = (mb == '0) ? '1 : ma / mb;
                i_div_remainder = (mb == '0) ? ma : ma % mb;
            end
        end
    end

    typedef struct {
        bit           sgn;
        logic [W-1:0] a, b;
        bit           exp_en;
        logic [W-1:0] exp_da, exp_db, exp_q, exp_r;
        bit           exp_dbz, exp_ovf;
    } vec_t;

    vec_t vecs[9];

    // Present a request after the current edge and let the next edge accept it.
    task automatic do_req(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        chk("req_ready_before_accept", {31'd0, o_req_ready}, 32'd1);
        i_signed    = sgn;
        i_dividend  = a;
        i_divisor   = b;
        i_req_valid = 1'b1;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
    endtask

    task automatic run_vec(input int idx, input int hold);
        vec_t v;
        int   c0, k;
        bit   found, dv_at, stable;
        logic [W-1:0] q0, r0;
        v  = vecs[idx];
        c0 = en_count;
        do_req(v.sgn, v.a, v.b);
        found = 1'b0; dv_at = 1'b0; k = 0;
        for (int t = 0; t < 40; t++) begin
            if (o_rsp_valid) begin found = 1'b1; dv_at = i_div_valid; k = t; break; end
            @(posedge i_clk); #1;
        end
        chk("rsp_seen", {31'd0, found}, 32'd1);
        if (v.exp_en) chk("latency_after_div_valid", {31'd0, dv_at}, 32'd1);
        else          chk("latency_bypass", k, 0);
        chk("quotient", o_quotient, v.exp_q);
        chk("remainder", o_remainder, v.exp_r);
        chk("div_by_zero", {31'd0, o_div_by_zero}, {31'd0, v.exp_dbz});
        chk("overflow", {31'd0, o_overflow}, {31'd0, v.exp_ovf});
        chk("timeout_flag", {31'd0, o_timeout}, 32'd0);
        chk("div_en_cycles", en_count - c0, v.exp_en ? 1 : 0);
        if (v.exp_en) begin
            chk("div_dividend", ma, v.exp_da);
            chk("div_divisor", mb, v.exp_db);
        end
        if (hold > 0) begin
            q0 = o_quotient; r0 = o_remainder; stable = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(posedge i_clk); #1;
                if (!(o_rsp_valid && !o_req_ready && o_quotient == q0 && o_remainder == r0))
                    stable = 1'b0;
            end
            chk("backpressure_stable", {31'd0, stable}, 32'd1);
        end
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        chk("released_to_idle", {30'd0, o_rsp_valid, o_req_ready}, 32'd1);
        chk("flags_cleared", {29'd0, o_div_by_zero, o_overflow, o_timeout}, 32'd0);
        $display("vec %0d: sgn=%0d a=0x%08h b=0x%08h -> q=0x%08h r=0x%08h", idx, v.sgn, v.a, v.b, v.exp_q, v.exp_r);
    endtask

    initial begin
        bit any_rsp;
        bit found;
        //            sgn  a             b             en  da            db            q             r             dbz ovf
        vecs[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'h00000007, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFFFFF9, 32'h00000002, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32'h00000001, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 32'h00000064, 32'h00000000, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000064, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0,        32'h0,        32'h80000000, 32'h00000000, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 1'b1, 32'h00000007, 32'h00000002, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, 32'h00000064, 32'h00000007, 32'h0000000E, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h80000000, 32'h00000002, 1'b1, 32'h80000000, 32'h00000002, 32'hC0000000, 32'h00000000, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 32'h00000005, 32'h00000000, 1'b0, 32'h0,        32'h0,        32'hFFFFFFFF, 32'h00000005, 1'b1, 1'b0};

        // Reset state
        #12;
        chk("reset_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("reset_outputs", {28'd0, o_rsp_valid, o_div_en, o_div_by_zero, o_overflow}, 32'd0);
        chk("reset_quotient", o_quotient | o_remainder | o_div_dividend | o_div_divisor, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Vector table; the first one also exercises 10 cycles of backpressure,
        // and each following request goes in the cycle right after release.
        for (int i = 0; i < 9; i++) run_vec(i, (i == 0) ? 10 : 0);

        // Reset while waiting on the divider, then a stray divider pulse.
        model_silent = 1'b1;
        do_req(1'b1, 32'd50, 32'd5);
        repeat (3) begin @(posedge i_clk); #1; end
        i_rst_n = 1'b0;
        #1;
        chk("midreset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
        chk("midreset_req_ready", {31'd0, o_req_ready}, 32'd1);
        chk("midreset_quotient", o_quotient, 32'd0);
        chk("midreset_div_operands", o_div_dividend | o_div_divisor, 32'd0);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        stray_req = 1'b1;
        any_rsp = 1'b0;
        repeat (8) begin
            @(posedge i_clk); #1;
            any_rsp |= o_rsp_valid | ~o_req_ready;
        end
        chk("stray_div_valid_ignored", {31'd0, any_rsp}, 32'd0);
        $display("reset-in-WAIT and stray divider pulse sequence done");

`ifdef SS_DIV_TIMEOUT_EN
        do_req(1'b0, 32'd9, 32'd3);
        found = 1'b0;
        for (int t = 0; t < TO + 50; t++) begin
            if (o_rsp_valid) begin found = 1'b1; break; end
            @(posedge i_clk); #1;
        end
        chk("timeout_rsp_seen", {31'd0, found}, 32'd1);
        chk("timeout_flag_set", {31'd0, o_timeout}, 32'd1);
        chk("timeout_quotient", o_quotient, 32'hFFFFFFFF);
        chk("timeout_remainder", o_remainder, 32'd0);
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        $display("watchdog timeout sequence done");
`else
        found = 1'b0;
`endif
        model_silent = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
